// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional macro ID_EX_SKID_BUBBLE_CNT_EN adds a saturating EX-starvation counter (bubble_cnt).
//
// state | meaning
// EMPTY | no beat held (M.valid=0, S.valid=0)
// HALF  | M holds the beat presented to EX, S empty
// FULL  | M presented to EX, S holds the younger beat; upstream stalled
module id_ex_skid_reg #(
    parameter int CTRL_W = 14,
    parameter int DATA_W = 134
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BAD   = 2'b01,
        ST_HALF  = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    state_e state;
    logic   accept;
    logic   pop;

    assign state     = state_e'({m_valid_q, s_valid_q});
    assign in_ready  = !s_valid_q && !rst;
    assign accept    = in_valid && in_ready;
    assign pop       = m_valid_q && out_ready;
    assign out_valid = m_valid_q;
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;

        if (flush) begin
            // Data registers keep stale contents; only valids and ctrl are squashed.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_ctrl_d  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_valid_d = 1'b1;
                        m_ctrl_d  = in_ctrl;
                        m_data_d  = in_data;
                    end
                end
                ST_HALF: begin
                    if (accept && pop) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (accept) begin
                        s_valid_d = 1'b1;
                        s_ctrl_d  = in_ctrl;
                        s_data_d  = in_data;
                    end else if (pop) begin
                        m_valid_d = 1'b0;
                        m_ctrl_d  = '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        m_ctrl_d  = s_ctrl_q;
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                        s_ctrl_d  = '0;
                    end
                end
                default: begin
                    // Unreachable; recover to EMPTY.
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                    m_ctrl_d  = '0;
                    s_ctrl_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end

`ifdef ID_EX_SKID_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (out_ready && !m_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Self-checking bench for id_ex_skid_reg: directed scenarios plus random traffic
// checked against a queue model of the stage (at most two beats, oldest presented).
module tb_id_ex_skid_reg;

    localparam int CW = 14;
    localparam int DW = 134;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
    int            bub_exp;
`endif

    id_ex_skid_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t q[$];
    int    total = 0;
    int    bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Compare every DUT output with what the queue model implies.
    task automatic check_state();
        int n;
        n = q.size();
        chk("in_ready", 256'(in_ready), 256'(!rst && n < 2));
        chk("out_valid", 256'(out_valid), 256'(n > 0));
        chk("occupancy", 256'(occupancy), 256'(n));
        chk("out_ctrl", 256'(out_ctrl), (n > 0) ? 256'(q[0].c) : 256'(0));
        if (n > 0) chk("out_data", 256'(out_data), 256'(q[0].d));
        if (rst) chk("out_data_rst", 256'(out_data), 256'(0));
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
        chk("bubble_cnt", 256'(bubble_cnt), 256'(bub_exp));
`endif
    endtask

    // Called just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        logic  acc;
        logic  pp;
        beat_t b;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_state();
        acc = iv && !rst && (q.size() < 2);
        pp  = ordy && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
            if (ordy && q.size() == 0 && bub_exp < 65535) bub_exp++;
`endif
            if (pp) void'(q.pop_front());
            if (acc) begin
                b.c = ic;
                b.d = id;
                q.push_back(b);
            end
            if (fl) q.delete();
        end
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        q.delete();
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
        bub_exp = 0;
`endif
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_ctrl", 256'(out_ctrl), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_occupancy", 256'(occupancy), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        @(negedge clk);
        cycle(1'b1, 14'h3FF, rnd_data(), 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef ID_EX_SKID_BUBBLE_CNT_EN
        bub_exp = 0;
`endif
        @(negedge clk);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // First beat after reset.
        cycle(1'b1, 14'h0A5, DW'(32'h1000), 1'b0, 1'b0);
        #1;
        chk("first_valid", 256'(out_valid), 256'(1));
        chk("first_ctrl", 256'(out_ctrl), 256'(14'h0A5));
        chk("first_occ", 256'(occupancy), 256'(1));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-to-back stream, no bubbles.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, CW'(i + 1), rnd_data(), 1'b1, 1'b0);
            chk("stream_valid", 256'(out_valid), 256'(1));
            chk("stream_ready", 256'(in_ready), 256'(1));
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // A, B fill the stage; C held upstream until the stage drains.
        cycle(1'b1, 14'h00A, rnd_data(), 1'b0, 1'b0);
        cycle(1'b1, 14'h00B, rnd_data(), 1'b0, 1'b0);
        chk("skid_occ", 256'(occupancy), 256'(2));
        chk("skid_in_ready", 256'(in_ready), 256'(0));
        cycle(1'b1, 14'h00C, DW'(32'hC), 1'b0, 1'b0);
        cycle(1'b1, 14'h00C, DW'(32'hC), 1'b1, 1'b0);
        cycle(1'b1, 14'h00C, DW'(32'hC), 1'b1, 1'b0);
        chk("skid_c_out", 256'(out_ctrl), 256'(14'h00C));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while FULL with an incoming beat D.
        cycle(1'b1, 14'h011, rnd_data(), 1'b0, 1'b0);
        cycle(1'b1, 14'h022, rnd_data(), 1'b0, 1'b0);
        cycle(1'b1, 14'h0DD, rnd_data(), 1'b0, 1'b1);
        chk("flush_valid", 256'(out_valid), 256'(0));
        chk("flush_ctrl", 256'(out_ctrl), 256'(0));
        chk("flush_occ", 256'(occupancy), 256'(0));
        chk("flush_in_ready", 256'(in_ready), 256'(1));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush in HALF discards a beat accepted the same cycle.
        cycle(1'b1, 14'h033, rnd_data(), 1'b0, 1'b0);
        cycle(1'b1, 14'h044, rnd_data(), 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Async reset while FULL, then beat E.
        cycle(1'b1, 14'h055, rnd_data(), 1'b0, 1'b0);
        cycle(1'b1, 14'h066, rnd_data(), 1'b0, 1'b0);
        async_reset();
        cycle(1'b1, 14'h0EE, DW'(32'hE), 1'b0, 1'b0);
        chk("e_valid", 256'(out_valid), 256'(1));
        chk("e_ctrl", 256'(out_ctrl), 256'(14'h0EE));

`ifdef ID_EX_SKID_BUBBLE_CNT_EN
        async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bubble_five", 256'(bubble_cnt), 256'(5));
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("bubble_flush", 256'(bubble_cnt), 256'(5));
`endif

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), CW'($urandom), rnd_data(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
